dec_pingpong_ram: RTL
=====================

# dec_pingpong_ram

Multi-bank decision memory for the LDPC decoder with a fill/consume handshake. The decoder core writes hard-decision words for codeword N into one bank while the output stage reads codeword N-1 from another. Banks rotate in a fixed ring under explicit commit/release handshakes, so the core can run ahead by up to NUM_BANKS-1 codewords. It replaces the fixed two-bank, caller-selected decision RAM with parametrised banking, internal bank ownership, read-valid signalling and error flags.

## Interface
- DATA_WIDTH, 1: bits per decision word.
- ADDR_WIDTH, 8: word address width; each bank holds 2^ADDR_WIDTH words.
- NUM_BANKS, 2: number of banks; legal values are 2 or more. BW = $clog2(NUM_BANKS); CW = $clog2(NUM_BANKS+1).
- clk  in  1  single clock; everything is sampled on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write wr_data to wr_addr in the current write bank.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_commit  in  1  marks the current write bank full and advances the write pointer.
- wr_ready  out  1  the current write bank is free (writes and commit accepted).
- wr_bank  out  BW  index of the current write bank.
- rd_en  in  1  read rd_addr from the current read bank.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_data_valid  out  1  rd_data holds the result of an accepted read.
- rd_release  in  1  frees the current read bank and advances the read pointer.
- rd_avail  out  1  the current read bank is full (reads and release accepted).
- rd_bank  out  BW  index of the current read bank.
- bank_count  out  CW  number of full (committed, unreleased) banks.
- wr_err  out  1  one-cycle pulse on a rejected wr_en or wr_commit.
- rd_err  out  1  one-cycle pulse on a rejected rd_en or rd_release.

## Operation
- State: wr_ptr, rd_ptr (BW bits each, wrap NUM_BANKS-1 -> 0) and count (0..NUM_BANKS). Storage: NUM_BANKS x 2^ADDR_WIDTH x DATA_WIDTH.
- Outputs: wr_ready = (count < NUM_BANKS); rd_avail = (count > 0); wr_bank = wr_ptr; rd_bank = rd_ptr; bank_count = count. All are combinational from registered state.
- Write: if wr_en && wr_ready, then mem[wr_ptr][wr_addr] <= wr_data. If wr_en && !wr_ready, the write is dropped and wr_err pulses.
- Commit: if wr_commit && wr_ready, wr_ptr advances and count increments. If wr_commit && !wr_ready, it is ignored and wr_err pulses.
- Read: if rd_en && rd_avail, rd_data <= mem[rd_ptr][rd_addr] and rd_data_valid <= 1. Otherwise rd_data_valid <= 0 and rd_data holds its value. If rd_en && !rd_avail, rd_err pulses.
- Release: if rd_release && rd_avail, rd_ptr advances and count decrements. If rd_release && !rd_avail, it is ignored and rd_err pulses.
- Accepted commit and accepted release in the same cycle: count is unchanged and both pointers advance.
- wr_en with wr_commit in the same cycle: the write lands in the bank being committed.
- rd_en with rd_release in the same cycle: the read uses the bank being released.
- Writer and reader never share a bank: the writer holds only free banks and the reader only full ones. Read-during-write to the same bank therefore cannot occur, and no bypass path exists.
- Commit does not check which addresses were written. Unwritten words return stale contents.

## Timing
- Reset, in the cycle after rst is sampled high: wr_ptr=0, rd_ptr=0, count=0. Hence wr_ready=1, rd_avail=0, bank_count=0, wr_bank=0, rd_bank=0, rd_data=0, rd_data_valid=0, wr_err=0, rd_err=0.
- rst has priority over every request in the same cycle; all requests in that cycle are discarded.
- Memory contents are not cleared by reset. Reset mid-frame abandons all banks.
- Write latency: data written in cycle t is readable, once its bank is committed, from cycle t+1.
- Read latency: 1 cycle. rd_en accepted in cycle t gives rd_data and rd_data_valid=1 after edge t+1. Back-to-back reads sustain one word per cycle.
- Handshake outputs update on the edge that samples an accepted commit or release.
  - After a commit in cycle t, rd_avail=1 from cycle t+1.
  - When count==NUM_BANKS, wr_ready=0 until a release is accepted. wr_ready returns to 1 in the cycle after the release.
- wr_err and rd_err are registered pulses, asserted in the cycle after the offending request.

## Test plan
- Reset then idle → wr_ready=1, rd_avail=0, bank_count=0, rd_data=0, rd_data_valid=0.
- NUM_BANKS=2, DATA_WIDTH=4: write addr 0..3 = 4'h1..4'h4, then commit. Read addr 0..3 on consecutive cycles → rd_data 1,2,3,4, each one cycle after its rd_en, with rd_data_valid high for exactly 4 cycles.
- Commit twice without release → bank_count=2, wr_ready=0. A further wr_en and a third commit → wr_err pulses twice, memory unchanged, wr_bank stays 0.
- With one bank full, write bank 1 while reading bank 0, then commit and release in the same cycle → bank_count stays 1, rd_bank=1, wr_bank=0. Reads return bank 1 data.
- rd_en and rd_release with rd_avail=0 → two rd_err pulses, rd_data_valid=0, pointers unchanged.
- NUM_BANKS=3: commit three times → wr_ready=0. Release, commit, then release three times → rd_bank sequence 0,1,2,0 (wrap), final bank_count=0.
- rst asserted mid-frame with bank_count=2 → all outputs return to their reset values one cycle later. A read after a fresh commit returns newly written data.

Source files
------------

// File: rtl/dec_pingpong_ram.sv
// dec_pingpong_ram: banked decision memory for the LDPC decoder.
// The writer fills free banks and the reader drains full banks. Both walk
// the same fixed ring, and ownership passes through commit/release handshakes.
module dec_pingpong_ram #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_BANKS  = 2,
    localparam int unsigned BW        = $clog2(NUM_BANKS),
    localparam int unsigned CW        = $clog2(NUM_BANKS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_commit,
    output logic                  wr_ready,
    output logic [BW-1:0]         wr_bank,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  rd_release,
    output logic                  rd_avail,
    output logic [BW-1:0]         rd_bank,
    output logic [CW-1:0]         bank_count,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Bank storage; never cleared, stale words are returned as-is.
    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

    logic [BW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [BW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_err_q, rd_err_d;

    logic wr_ok_c;
    logic commit_ok_c;
    logic rd_ok_c;
    logic release_ok_c;

    // Ring successor of a bank index.
    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == BW'(NUM_BANKS - 1)) ? '0 : p + BW'(1);
    endfunction

    // Handshake status is derived directly from the registered pointers/count.
    assign wr_ready      = (count_q < CW'(NUM_BANKS));
    assign rd_avail      = (count_q != '0);
    assign wr_bank       = wr_ptr_q;
    assign rd_bank       = rd_ptr_q;
    assign bank_count    = count_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign wr_err        = wr_err_q;
    assign rd_err        = rd_err_q;

    // Request acceptance and next pointer/count state.
    always_comb begin
        wr_ok_c      = wr_en      && wr_ready && !rst;
        commit_ok_c  = wr_commit  && wr_ready && !rst;
        rd_ok_c      = rd_en      && rd_avail && !rst;
        release_ok_c = rd_release && rd_avail && !rst;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        wr_err_d     = (wr_en || wr_commit)  && !wr_ready;
        rd_err_d     = (rd_en || rd_release) && !rd_avail;

        if (commit_ok_c) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (release_ok_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Simultaneous commit and release leave the count unchanged.
        case ({commit_ok_c, release_ok_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, read port register and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_ok_c;
            wr_err_q   <= wr_err_d;
            rd_err_q   <= rd_err_d;
            if (rd_ok_c) begin
                rd_data_q <= mem[rd_ptr_q][rd_addr];
            end
        end
    end

    // Write port into the bank currently owned by the writer.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_ptr_q][wr_addr] <= wr_data;
        end
    end

endmodule
